line_addr_sequencer: RTL and testbench

// Next-generation line read-address sequencer for the X_MESH x X_MAC buffer array.
// It accepts one line command per valid/ready handshake and walks the line at two pixels per beat.
// It drives per-channel read addresses with a programmable word stride and optional left pad.
// Mux control, out_valid and the tofifo/fromfifo tags are aligned to the buffer read data.
// A hold input stalls the whole pipeline, and back-to-back commands run without a bubble.

---
 rtl/line_addr_sequencer_if.sv | 27 ++
 rtl/line_addr_sequencer.sv | 159 +++++++++++++++
 tb/tb_line_addr_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_addr_sequencer_if.sv
// Command channel of the line read-address sequencer: one line command per
// valid/ready handshake. The master offers commands; the sequencer is the slave.
interface line_addr_sequencer_if #(
  parameter int X_MAC        = 4,
  parameter int ADDR_LEN     = 13,
  parameter int MAX_LINE_LEN = 10,
  parameter int STRIDE_LEN   = 4
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [X_MAC*ADDR_LEN-1:0] cmd_st_addr;
  logic [MAX_LINE_LEN-1:0]   cmd_linelen;
  logic                      cmd_pad;
  logic [STRIDE_LEN-1:0]     cmd_stride;
  logic                      cmd_tofifo;
  logic                      cmd_fromfifo;

  modport master (
    output cmd_valid, cmd_st_addr, cmd_linelen, cmd_pad, cmd_stride, cmd_tofifo, cmd_fromfifo,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_st_addr, cmd_linelen, cmd_pad, cmd_stride, cmd_tofifo, cmd_fromfifo,
    output cmd_ready
  );
endinterface

// File: rtl/line_addr_sequencer.sv
// Line read-address sequencer for the X_MESH x X_MAC buffer array.
// Walks one line at two pixels per beat, driving per-channel word addresses
// (start + stride * word index, wrapping) replicated to every mesh column.
// Per-beat mux control and tags travel through a PIPE_LAT-deep pipe so they
// line up with the buffer read data. hold freezes everything.
module line_addr_sequencer #(
  parameter int X_MAC        = 4,
  parameter int X_MESH       = 16,
  parameter int ADDR_LEN     = 13,
  parameter int MAX_LINE_LEN = 10,
  parameter int STRIDE_LEN   = 4,
  parameter int MUXCONTROL   = 4,
  parameter int PIPE_LAT     = 2,
  parameter int IDLE_THRESH  = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  line_addr_sequencer_if.slave               cmd,
  input  logic                               hold,
  output logic [X_MESH*X_MAC*ADDR_LEN-1:0]   addrb,
  output logic [MUXCONTROL-1:0]              control_out,
  output logic                               out_valid,
  output logic                               pe_tofifo,
  output logic                               pe_fromfifo,
  output logic                               busy,
  output logic                               idle_soon
);
  // Beat indices fit in MAX_LINE_LEN bits: at most 512 beats for a 10-bit length.
  localparam int BEAT_W = MAX_LINE_LEN;
  localparam logic [BEAT_W-1:0] BEAT_ZERO = {BEAT_W{1'b0}};
  localparam logic [BEAT_W-1:0] BEAT_ONE  = {{(BEAT_W-1){1'b0}}, 1'b1};
  localparam logic [BEAT_W-1:0] IDLE_CMP  = BEAT_W'(IDLE_THRESH);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  typedef struct packed {
    logic valid;
    logic last;
    logic pad;
    logic phase;
    logic tofifo;
    logic fromfifo;
  } beat_info_t;

  state_t                         state_r;
  logic [BEAT_W-1:0]              beat_r;
  logic [BEAT_W-1:0]              last_beat_r;
  logic [STRIDE_LEN-1:0]          stride_r;
  logic                           pad_r;
  logic                           tofifo_r;
  logic                           fromfifo_r;
  logic [X_MAC-1:0][ADDR_LEN-1:0] addr_r;
  beat_info_t                     pipe_r [PIPE_LAT];

  logic              on_last_s;
  logic              cmd_ready_s;
  logic              accept_s;
  logic              start_s;
  logic [BEAT_W-1:0] new_last_s;
  logic [BEAT_W-1:0] remain_s;
  beat_info_t        beat_info_s;

  // Handshake decode and last-beat index of an offered line.
  // ceil((len+pad)/2) = len/2 + (pad | len odd); the last index is one less.
  always_comb begin
    on_last_s   = (state_r == ST_RUN) && (beat_r == last_beat_r);
    cmd_ready_s = !hold && ((state_r == ST_IDLE) || on_last_s);
    accept_s    = cmd.cmd_valid && cmd_ready_s;
    start_s     = accept_s && (cmd.cmd_linelen != {MAX_LINE_LEN{1'b0}});
    new_last_s  = {1'b0, cmd.cmd_linelen[MAX_LINE_LEN-1:1]}
                + {{(BEAT_W-1){1'b0}}, (cmd.cmd_pad | cmd.cmd_linelen[0])}
                - BEAT_ONE;
    remain_s    = last_beat_r - beat_r + BEAT_ONE;
  end

  // Describe the beat currently on addrb; all-zero when no beat is issued.
  always_comb begin
    beat_info_s = 6'b000000;
    if (state_r == ST_RUN) begin
      beat_info_s.valid    = 1'b1;
      beat_info_s.last     = (beat_r == last_beat_r);
      beat_info_s.pad      = pad_r;
      beat_info_s.phase    = beat_r[0];
      beat_info_s.tofifo   = tofifo_r;
      beat_info_s.fromfifo = fromfifo_r;
    end else begin
      beat_info_s.valid    = 1'b0;
    end
  end

  // Line sequencer: state, beat counter, latched command fields and channel addresses.
  // The word address steps after every odd beat, so beats 2w and 2w+1 share word w.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      beat_r      <= BEAT_ZERO;
      last_beat_r <= BEAT_ZERO;
      stride_r    <= {STRIDE_LEN{1'b0}};
      pad_r       <= 1'b0;
      tofifo_r    <= 1'b0;
      fromfifo_r  <= 1'b0;
      addr_r      <= {(X_MAC*ADDR_LEN){1'b0}};
    end else if (!hold) begin
      if (start_s) begin
        state_r     <= ST_RUN;
        beat_r      <= BEAT_ZERO;
        last_beat_r <= new_last_s;
        stride_r    <= cmd.cmd_stride;
        pad_r       <= cmd.cmd_pad;
        tofifo_r    <= cmd.cmd_tofifo;
        fromfifo_r  <= cmd.cmd_fromfifo;
        addr_r      <= cmd.cmd_st_addr;
      end else if (on_last_s) begin
        state_r <= ST_IDLE;
      end else if (state_r == ST_RUN) begin
        beat_r <= beat_r + BEAT_ONE;
        if (beat_r[0]) begin
          for (int j = 0; j < X_MAC; j++) begin
            addr_r[j] <= addr_r[j] + ADDR_LEN'(stride_r);
          end
        end
      end
    end
  end

  // Read-data alignment pipe for per-beat control and tags, frozen by hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_r[i] <= 6'b000000;
      end
    end else if (!hold) begin
      pipe_r[0] <= beat_info_s;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  // Output decode straight from registers; addresses are copied to every column.
  always_comb begin
    control_out      = {MUXCONTROL{1'b0}};
    control_out[2:0] = {pipe_r[PIPE_LAT-1].last, pipe_r[PIPE_LAT-1].pad, pipe_r[PIPE_LAT-1].phase};
    out_valid        = pipe_r[PIPE_LAT-1].valid;
    pe_tofifo        = pipe_r[PIPE_LAT-1].valid & pipe_r[PIPE_LAT-1].tofifo;
    pe_fromfifo      = pipe_r[PIPE_LAT-1].valid & pipe_r[PIPE_LAT-1].fromfifo;
    busy             = (state_r == ST_RUN);
    idle_soon        = (state_r != ST_RUN) || (remain_s < IDLE_CMP);
    addrb            = {(X_MESH*X_MAC*ADDR_LEN){1'b0}};
    for (int i = 0; i < X_MESH; i++) begin
      for (int j = 0; j < X_MAC; j++) begin
        addrb[(i*X_MAC+j)*ADDR_LEN +: ADDR_LEN] = addr_r[j];
      end
    end
  end

  assign cmd.cmd_ready = cmd_ready_s;

endmodule

// File: tb/tb_line_addr_sequencer.sv
// Bench for line_addr_sequencer: directed scenarios then random traffic,
// checked every cycle against a beat-queue reference model.
module tb_line_addr_sequencer;
  localparam int X_MAC        = 4;
  localparam int X_MESH       = 16;
  localparam int ADDR_LEN     = 13;
  localparam int MAX_LINE_LEN = 10;
  localparam int STRIDE_LEN   = 4;
  localparam int MUXCONTROL   = 4;
  localparam int PIPE_LAT     = 2;
  localparam int IDLE_THRESH  = 5;
  localparam int AW           = X_MESH*X_MAC*ADDR_LEN;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  hold;
  logic [AW-1:0]         addrb;
  logic [MUXCONTROL-1:0] control_out;
  logic                  out_valid, pe_tofifo, pe_fromfifo, busy, idle_soon;

  line_addr_sequencer_if #(.X_MAC(X_MAC), .ADDR_LEN(ADDR_LEN),
                           .MAX_LINE_LEN(MAX_LINE_LEN), .STRIDE_LEN(STRIDE_LEN)) bus ();

  line_addr_sequencer #(.X_MAC(X_MAC), .X_MESH(X_MESH), .ADDR_LEN(ADDR_LEN),
                        .MAX_LINE_LEN(MAX_LINE_LEN), .STRIDE_LEN(STRIDE_LEN),
                        .MUXCONTROL(MUXCONTROL), .PIPE_LAT(PIPE_LAT),
                        .IDLE_THRESH(IDLE_THRESH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(bus), .hold(hold), .addrb(addrb),
    .control_out(control_out), .out_valid(out_valid), .pe_tofifo(pe_tofifo),
    .pe_fromfifo(pe_fromfifo), .busy(busy), .idle_soon(idle_soon)
  );

  always #5 clk = ~clk;

  // Reference model: a line becomes a queue of beats; one beat leaves per
  // unheld cycle and its description re-emerges PIPE_LAT unheld cycles later.
  typedef struct {
    logic [X_MAC-1:0][ADDR_LEN-1:0] addr;
    bit phase, last, pad, tof, frf;
  } beat_t;

  beat_t                          q[$];
  beat_t                          cur;
  bit                             cur_v;
  logic [X_MAC-1:0][ADDR_LEN-1:0] shown;
  beat_t                          pq [PIPE_LAT];
  bit                             pv [PIPE_LAT];
  bit                             last_acc;
  int n_checks = 0, n_pass = 0, n_fail = 0;

  function automatic bit m_ready();
    return !hold && (!cur_v || cur.last);
  endfunction

  task automatic model_reset();
    q.delete();
    cur   = '{default: '0};
    cur_v = 1'b0;
    shown = '0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      pv[i] = 1'b0;
      pq[i] = '{default: '0};
    end
  endtask

  task automatic push_line();
    int    len, p, nb, s;
    beat_t b;
    len = int'(bus.cmd_linelen);
    p   = int'(bus.cmd_pad);
    nb  = (len + p + 1) / 2;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < X_MAC; j++) begin
        s = (int'(bus.cmd_st_addr[j*ADDR_LEN +: ADDR_LEN]) + int'(bus.cmd_stride) * (k / 2)) % (1 << ADDR_LEN);
        b.addr[j] = s[ADDR_LEN-1:0];
      end
      b.phase = (k % 2) == 1;
      b.last  = (k == nb - 1);
      b.pad   = (p == 1);
      b.tof   = bus.cmd_tofifo;
      b.frf   = bus.cmd_fromfifo;
      q.push_back(b);
    end
  endtask

  task automatic model_edge();
    bit acc;
    if (!rst_n) begin
      model_reset();
      last_acc = 1'b0;
      return;
    end
    acc      = bus.cmd_valid && m_ready();
    last_acc = acc;
    if (hold) return;
    for (int i = PIPE_LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pq[i] = pq[i-1];
    end
    pv[0] = cur_v;
    pq[0] = cur;
    if (acc && bus.cmd_linelen != '0) push_line();
    if (q.size() > 0) begin
      cur   = q.pop_front();
      cur_v = 1'b1;
      shown = cur.addr;
    end else begin
      cur_v = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    logic [AW-1:0]         ea;
    logic [MUXCONTROL-1:0] ec;
    beat_t                 t;
    for (int i = 0; i < X_MESH; i++)
      for (int j = 0; j < X_MAC; j++)
        ea[(i*X_MAC+j)*ADDR_LEN +: ADDR_LEN] = shown[j];
    t  = pq[PIPE_LAT-1];
    ec = '0;
    if (pv[PIPE_LAT-1]) ec[2:0] = {t.last, t.pad, t.phase};
    n_checks++;
    assert (addrb === ea) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s.addrb: observed %h expected %h", ph, addrb, ea);
    end
    chk({ph, ".cmd_ready"},   64'(bus.cmd_ready), 64'(m_ready()));
    chk({ph, ".control_out"}, 64'(control_out),   64'(ec));
    chk({ph, ".out_valid"},   64'(out_valid),     64'(pv[PIPE_LAT-1]));
    chk({ph, ".pe_tofifo"},   64'(pe_tofifo),     64'(pv[PIPE_LAT-1] && t.tof));
    chk({ph, ".pe_fromfifo"}, 64'(pe_fromfifo),   64'(pv[PIPE_LAT-1] && t.frf));
    chk({ph, ".busy"},        64'(busy),          64'(cur_v));
    chk({ph, ".idle_soon"},   64'(idle_soon),     64'(!cur_v || (q.size() + 1 < IDLE_THRESH)));
  endtask

  task automatic cycle(input string ph);
    @(negedge clk);
    check_all(ph);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_fields();
    bus.cmd_st_addr  = (X_MAC*ADDR_LEN)'({$urandom, $urandom});
    bus.cmd_linelen  = ($urandom_range(0, 9) == 0) ? '0 : MAX_LINE_LEN'($urandom_range(1, 40));
    bus.cmd_pad      = 1'($urandom_range(0, 1));
    bus.cmd_stride   = STRIDE_LEN'($urandom_range(0, 15));
    bus.cmd_tofifo   = 1'($urandom_range(0, 1));
    bus.cmd_fromfifo = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input string ph, input logic [ADDR_LEN-1:0] st, input int len,
                       input bit p, input int stride, input bit tf, input bit ff);
    bus.cmd_st_addr  = {X_MAC{st}};
    bus.cmd_linelen  = MAX_LINE_LEN'(len);
    bus.cmd_pad      = p;
    bus.cmd_stride   = STRIDE_LEN'(stride);
    bus.cmd_tofifo   = tf;
    bus.cmd_fromfifo = ff;
    bus.cmd_valid    = 1'b1;
    last_acc         = 1'b0;
    for (int n = 0; n < 64 && !last_acc; n++) cycle(ph);
    chk({ph, ".accepted"}, 64'(last_acc), 64'(1));
    bus.cmd_valid = 1'b0;
    rand_fields();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [ADDR_LEN-1:0] seen [4];
    int                  wrap_exp [4] = '{8191, 8191, 0, 0};

    rst_n         = 1'b0;
    hold          = 1'b0;
    bus.cmd_valid = 1'b0;
    rand_fields();
    model_reset();
    last_acc = 1'b0;
    cycle("reset");
    cycle("reset");
    rst_n = 1'b1;
    cycle("post_reset");

    // T1: plain line, stride 1
    issue("t1", 13'd100, 8, 1'b0, 1, 1'b1, 1'b0);
    repeat (8) cycle("t1");

    // T2: padded odd line, stride 2
    issue("t2", 13'd40, 7, 1'b1, 2, 1'b0, 1'b1);
    repeat (8) cycle("t2");

    // T3: back-to-back lines with different tags
    issue("t3a", 13'd200, 4, 1'b0, 3, 1'b1, 1'b0);
    issue("t3b", 13'd300, 4, 1'b1, 1, 1'b0, 1'b1);
    repeat (8) cycle("t3");

    // T4: hold for 3 cycles at beat 2
    issue("t4", 13'd500, 10, 1'b0, 1, 1'b1, 1'b1);
    repeat (2) cycle("t4");
    hold = 1'b1;
    bus.cmd_valid = 1'b1;
    repeat (3) cycle("t4_hold");
    bus.cmd_valid = 1'b0;
    hold = 1'b0;
    repeat (10) cycle("t4");

    // T5: address wrap
    issue("t5", 13'd8191, 8, 1'b0, 1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      seen[k] = addrb[ADDR_LEN-1:0];
      cycle("t5");
    end
    for (int k = 0; k < 4; k++) chk("t5.wrap_addr", 64'(seen[k]), 64'(wrap_exp[k]));
    repeat (4) cycle("t5");

    // T5b: zero-length command
    issue("t5b", 13'd7, 0, 1'b0, 1, 1'b1, 1'b1);
    repeat (6) cycle("t5b");

    // T6: asynchronous reset mid-line
    issue("t6", 13'd1000, 20, 1'b1, 5, 1'b1, 1'b0);
    repeat (3) cycle("t6");
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    #1 rst_n = 1'b1;
    cycle("t6_after");
    issue("t6_fresh", 13'd77, 6, 1'b0, 2, 1'b0, 1'b1);
    repeat (8) cycle("t6_fresh");

    // Random traffic with random hold
    for (int c = 0; c < 1500; c++) begin
      hold          = ($urandom_range(0, 7) == 0);
      bus.cmd_valid = ($urandom_range(0, 2) == 0);
      rand_fields();
      cycle("rand");
    end
    hold          = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (40) cycle("drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
